// File: rtl/inv_key_sched_pkg.sv
// Shared AES-128 constants, types and GF(2^8) helpers for the inverse key schedule.
package inv_key_sched_pkg;

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NIB_W      = BYTE_W / 2;
  localparam int unsigned WORDS      = WORD_W / BYTE_W;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned NUM_ROUNDS = 10;

  // Rcon bytes for rounds 1..10, stored at index round-1.
  localparam logic [BYTE_W-1:0] RCON_TBL [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Round key viewed as four 32-bit words; w0 holds key bytes 0..3.
  typedef struct packed {
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
  } key_words_t;

  // Rcon word for round r; zero outside 1..10.
  function automatic logic [WORD_W-1:0] rcon_word(input logic [ROUND_W-1:0] r);
    logic [WORD_W-1:0] rc;
    rc = '0;
    if ((r != '0) && (r <= ROUND_W'(NUM_ROUNDS))) begin
      rc = {RCON_TBL[r - ROUND_W'(1)], {(WORD_W - BYTE_W){1'b0}}};
    end
    return rc;
  endfunction

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] acc;
    logic [BYTE_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h1b) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // AES S-box: multiplicative inverse (x^254, so 0 maps to 0) then affine map.
  function automatic logic [BYTE_W-1:0] sbox_byte(input logic [BYTE_W-1:0] x);
    logic [BYTE_W-1:0] t;
    logic [BYTE_W-1:0] p;
    t = x;
    p = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      p = gf_mul(p, t);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^
           {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/inv_key_sched_sbox.sv
// AES forward S-box, purely combinational.
//   hi_nib : upper nibble of the input byte
//   lo_nib : lower nibble of the input byte
//   sub_c  : substituted byte
module inv_key_sched_sbox
  import inv_key_sched_pkg::*;
(
  input  logic [NIB_W-1:0]  hi_nib,
  input  logic [NIB_W-1:0]  lo_nib,
  output logic [BYTE_W-1:0] sub_c
);

  assign sub_c = sbox_byte({hi_nib, lo_nib});

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 inverse key schedule: walks from the round-10 key back to round 0,
// presenting one round key per valid/ready handshake.
//   clk, rst_n : clock, async active-low reset
//   start      : begin a schedule (sampled only when idle)
//   last_key   : round-10 key, byte 0 at [0:7]
//   key_out    : current round key, same byte order as last_key
//   round_num  : round index of key_out (10 down to 0)
//   key_valid  : key_out/round_num valid
//   key_ready  : consumer accepts key_out when key_valid is also high
//   busy       : schedule in progress
//   done       : one-cycle pulse after the round-0 key is accepted
module inv_key_sched
  import inv_key_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [0:KEY_W-1]   last_key,
  output logic [0:KEY_W-1]   key_out,
  output logic [ROUND_W-1:0] round_num,
  output logic               key_valid,
  input  logic               key_ready,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [0:KEY_W-1]   key_q, key_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  key_words_t         cur_w;
  key_words_t         prev_w;
  logic [WORD_W-1:0]  w3_prev;
  logic [WORD_W-1:0]  rot_w;
  logic [WORD_W-1:0]  sub_w;
  logic [0:KEY_W-1]   prev_key_c;

  assign cur_w = key_q;

  // Undo the forward XOR chain; w3 of the previous round feeds SubWord.
  assign w3_prev = cur_w.w3 ^ cur_w.w2;
  assign rot_w   = {w3_prev[WORD_W-BYTE_W-1:0], w3_prev[WORD_W-1 -: BYTE_W]};

  for (genvar g = 0; g < WORDS; g++) begin : g_sbox
    inv_key_sched_sbox u_sbox (
      .hi_nib (rot_w[WORD_W-1-g*BYTE_W -: NIB_W]),
      .lo_nib (rot_w[WORD_W-1-g*BYTE_W-NIB_W -: NIB_W]),
      .sub_c  (sub_w[WORD_W-1-g*BYTE_W -: BYTE_W])
    );
  end

  // Previous-round key; Rcon is indexed by the current (later) round.
  always_comb begin
    prev_w    = cur_w;
    prev_w.w3 = w3_prev;
    prev_w.w2 = cur_w.w2 ^ cur_w.w1;
    prev_w.w1 = cur_w.w1 ^ cur_w.w0;
    prev_w.w0 = cur_w.w0 ^ sub_w ^ rcon_word(round_q);
  end

  assign prev_key_c = prev_w;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          round_d = ROUND_W'(NUM_ROUNDS);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (round_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key_c;
            round_d = round_q - ROUND_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == EMIT);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key_out   = key_q;
  assign round_num = round_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_inv_key_sched.sv
// Directed bench for inv_key_sched: FIPS-197 vector, backpressure, ignored
// start, mid-schedule reset, back-to-back schedules and forward/inverse round trip.
module tb_inv_key_sched;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [0:127]   last_key;
  logic [0:127]   key_out;
  logic [3:0]     round_num;
  logic           key_valid;
  logic           key_ready;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [7:0] RC [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [127:0] fwd [0:10];
  logic [127:0] got [0:10];
  logic [127:0] rkey;
  bit           fin;

  always #5 clk = ~clk;

  inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_key  (last_key),
    .key_out   (key_out),
    .round_num (round_num),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      idx = int'(w[31-8*i -: 8]);
      r[31-8*i -: 8] = SBOX[idx*8 +: 8];
    end
    return r;
  endfunction

  // Forward AES-128 key expansion into fwd[0..10].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {RC[i/4], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) fwd[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one schedule starting from fwd[10]; expects fwd[r] at each round.
  task automatic run_sched(input string name, input bit toggle, input bit poke);
    int  r;
    bit  acc;
    bit  ended;
    r = 10;
    ended = 1'b0;
    last_key  = fwd[10];
    start     = 1'b1;
    key_ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 60 && !ended; cyc++) begin
      acc = 1'b0;
      if (r >= 0) begin
        check($sformatf("%s_r%0d_valid", name, r), 128'(key_valid), 128'(1));
        check($sformatf("%s_r%0d_busy", name, r), 128'(busy), 128'(1));
        check($sformatf("%s_r%0d_num", name, r), 128'(round_num), 128'(r));
        check($sformatf("%s_r%0d_key", name, r), key_out, fwd[r]);
        check($sformatf("%s_r%0d_done", name, r), 128'(done), 128'(0));
        key_ready = toggle ? (cyc % 2 == 0) : 1'b1;
        acc = key_ready;
        if (acc) got[r] = key_out;
        if (poke) begin
          start    = (cyc == 4);
          last_key = (cyc == 4) ? ~fwd[10] : fwd[10];
        end
      end else begin
        check($sformatf("%s_done", name), 128'(done), 128'(1));
        check($sformatf("%s_end_valid", name), 128'(key_valid), 128'(0));
        check($sformatf("%s_end_busy", name), 128'(busy), 128'(0));
        if (!toggle) check($sformatf("%s_done_cycle", name), 128'(cyc), 128'(12));
        ended = 1'b1;
      end
      step();
      if (acc) r--;
    end
    check($sformatf("%s_finished", name), 128'(ended), 128'(1));
    check($sformatf("%s_done_pulse", name), 128'(done), 128'(0));
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    key_ready = 1'b0;
    last_key  = '0;
    step();
    step();
    check("rst_key", key_out, 128'h0);
    check("rst_round", 128'(round_num), 128'(0));
    check("rst_valid", 128'(key_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    step();

    // FIPS-197 appendix A.1 schedule.
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_sched("fips", 1'b0, 1'b0);
    check("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_r9", got[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    run_sched("bp", 1'b1, 1'b0);
    check("bp_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_sched("poke", 1'b0, 1'b1);

    // Reset while round 5 is presented.
    last_key  = fwd[10];
    start     = 1'b1;
    key_ready = 1'b1;
    step();
    start = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 20 && !fin; i++) begin
      if (key_valid && round_num == 4'd5) fin = 1'b1;
      else step();
    end
    check("mid_rst_reach_r5", 128'(fin), 128'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_key", key_out, 128'h0);
    check("mid_rst_round", 128'(round_num), 128'(0));
    check("mid_rst_valid", 128'(key_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    repeat (2) begin
      step();
      check("in_rst_valid", 128'(key_valid), 128'(0));
      check("in_rst_done", 128'(done), 128'(0));
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_valid", 128'(key_valid), 128'(0));
      check("post_rst_done", 128'(done), 128'(0));
      check("post_rst_busy", 128'(busy), 128'(0));
    end
    run_sched("fresh", 1'b0, 1'b0);

    // start held high across done.
    last_key  = fwd[10];
    start     = 1'b1;
    key_ready = 1'b1;
    step();
    for (int cyc = 1; cyc <= 13; cyc++) begin
      if (cyc <= 11) begin
        check($sformatf("b2b_c%0d_valid", cyc), 128'(key_valid), 128'(1));
        check($sformatf("b2b_c%0d_num", cyc), 128'(round_num), 128'(11 - cyc));
        check($sformatf("b2b_c%0d_key", cyc), key_out, fwd[11-cyc]);
      end else if (cyc == 12) begin
        check("b2b_done", 128'(done), 128'(1));
        check("b2b_done_valid", 128'(key_valid), 128'(0));
      end else begin
        check("b2b_second_valid", 128'(key_valid), 128'(1));
        check("b2b_second_num", 128'(round_num), 128'(10));
        check("b2b_second_key", key_out, fwd[10]);
        start = 1'b0;
      end
      if (cyc < 13) step();
    end
    fin = 1'b0;
    for (int i = 0; i < 30 && !fin; i++) begin
      step();
      fin = done;
    end
    check("b2b_drain_done", 128'(fin), 128'(1));
    step();

    // Forward expansion of random keys, then invert from round 10.
    for (int n = 0; n < 3; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      expand(rkey);
      run_sched($sformatf("rt%0d", n), n[0], 1'b0);
      check($sformatf("rt%0d_orig", n), got[0], rkey);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: start  input  1  request to begin a schedule; sampled only in IDLE.
REQ-004 SHALL have port: last_key  input  [0:127]  AES-128 round-10 key; byte 0 at [0:7]; column-major, 4 bytes per word.
REQ-005 SHALL have port: key_out  output  [0:127]  current round key, same bit order as last_key.
REQ-006 SHALL have port: round_num  output  [3:0]  round index of key_out, 10 down to 0.
REQ-007 SHALL have port: key_valid  output  1  key_out/round_num valid.
REQ-008 SHALL have port: key_ready  input  1  consumer accepts key_out when key_valid and key_ready are both 1.
REQ-009 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse after the round-0 key is accepted.

Function
REQ-011 SHALL implement the two states IDLE and EMIT.
REQ-012 In IDLE with start=1 SHALL capture last_key into the key register, set round to 10 and move to EMIT.
REQ-013 SHALL assert key_valid on the first cycle after start is sampled, with round_num=10 and key_out=last_key.
REQ-014 In EMIT SHALL hold key_out, round_num and key_valid stable while key_ready=0.
REQ-015 On acceptance with round_num>0 SHALL load the round-(r-1) key and decrement round_num; the new key_valid appears the next cycle with no bubble.
REQ-016 Inverse step, with words w0..w3 of round r: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon[r].
REQ-017 RotWord SHALL rotate bytes left by one: (b0,b1,b2,b3)->(b1,b2,b3,b0).
REQ-018 Rcon[r] SHALL be {rc,00,00,00}, with rc for r=1..10 equal to 01,02,04,08,10,20,40,80,1b,36.
REQ-019 On acceptance with round_num=0, next cycle SHALL give: key_valid=0, done=1 for one cycle, state IDLE.
REQ-020 start while busy SHALL be ignored.
REQ-021 start in the same cycle that done is high SHALL be accepted, since the FSM is then in IDLE.
REQ-022 With key_ready held at 1, the timing SHALL be: start sampled at cycle t; round r valid at cycle t+11-r; done at cycle t+12.
REQ-023 All outputs SHALL be registered; key_out SHALL NOT depend combinationally on key_ready.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, key_out=0, round_num=0, key_valid=0, busy=0, done=0.
REQ-025 Reset mid-schedule SHALL abandon the schedule with no further key_valid or done.
REQ-026 After rst_n deasserts, the first start SHALL behave exactly as in REQ-012/013.

Structure
REQ-027 The Rcon byte table (10 entries) and the constant 10 (AES-128 round count) SHALL live in the shared AES package/include.
REQ-028 SubWord SHALL use four instances of the existing sbox sub-module: high nibble in, low nibble in, byte out.
REQ-029 The sbox instances SHALL be fed from w3' computed combinationally from the key register.
REQ-030 The block SHALL contain only one datapath register (128 bits) and a 4-bit round counter; no per-round key storage.

Verification
REQ-031 FIPS-197 vector, key_ready=1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done at t+12.
REQ-032 Backpressure: same vector, key_ready toggled 0/1 per cycle -> same 11 keys, in order, each held stable while stalled; none dropped or duplicated.
REQ-033 start pulsed during EMIT with a different last_key -> ignored; sequence unchanged.
REQ-034 rst_n asserted while round_num=5 -> outputs zero immediately; no done; a fresh start then yields a correct round-10 key.
REQ-035 Back-to-back: start held high across done -> second schedule begins; round 10 valid the cycle after done.
REQ-036 Round-trip: for random keys, the forward key expansion gives round 10; feeding that as last_key SHALL reproduce every forward round key exactly.
